// File: rtl/zzadd_pipe.sv
// Chunked, stall-able pipelined adder: one WIDTH/STAGES-bit chunk per stage, carries rippled through flops.
// Optional overflow flag enabled by defining ZZADD_PIPE_OVF_EN (ovf tied low otherwise).
module zzadd_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             cin,
  input  logic             sub,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] adder_out,
  output logic             cout_half,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW  = WIDTH / STAGES;
  localparam int unsigned HS  = (WIDTH / 2 - 1) / CW;
  localparam logic [CW:0] ONE = (CW + 1)'(1);

  logic stall;
  logic en;

  assign stall  = out_vld & ~out_rdy;
  assign en     = ~stall;
  assign in_rdy = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned RW = WIDTH - k * CW;

    logic [RW-1:0]         a_in;
    logic [RW-1:0]         b_in;
    logic                  c_in;
    logic                  v_in;
    logic                  c_nx;
    logic [CW-1:0]         s_nx;
    logic [(k+1)*CW-1:0]   r_nx;
    logic                  v_q;
    logic                  c_q;
    logic [(k+1)*CW-1:0]   r_q;

    if (k == 0) begin : g_head
      assign a_in = rs1_data;
      assign b_in = sub ? ~rs2_data : rs2_data;
      assign c_in = cin;
      assign v_in = in_vld;
      assign r_nx = s_nx;
    end else begin : g_tail
      assign a_in = g_st[k-1].g_fwd.a_q;
      assign b_in = g_st[k-1].g_fwd.b_q;
      assign c_in = g_st[k-1].c_q;
      assign v_in = g_st[k-1].v_q;
      assign r_nx = {s_nx, g_st[k-1].r_q};
    end

    assign {c_nx, s_nx} = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + (CW + 1)'(c_in);

    always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= c_nx;
        r_q <= r_nx;
      end
    end

    // Operand bits not yet consumed travel with the partial result.
    if (k < STAGES - 1) begin : g_fwd
      logic [RW-CW-1:0] a_q;
      logic [RW-CW-1:0] b_q;

      always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[RW-1:CW];
          b_q <= b_in[RW-1:CW];
        end
      end
    end

    // Half carry may fall mid-chunk: add only the bits below WIDTH/2 and test for spill past them.
    if (k >= HS) begin : g_h
      logic h_nx;
      logic h_q;

      if (k == HS) begin : g_calc
        localparam int unsigned HL = WIDTH / 2 - k * CW;
        localparam logic [CW:0] HM = (ONE << HL) - ONE;
        logic [CW:0] h_sum;

        assign h_sum = {1'b0, a_in[CW-1:0] & HM[CW-1:0]}
                     + {1'b0, b_in[CW-1:0] & HM[CW-1:0]}
                     + (CW + 1)'(c_in);
        assign h_nx  = h_sum > HM;
      end else begin : g_pass
        assign h_nx = g_st[k-1].g_h.h_q;
      end

      always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l)  h_q <= 1'b0;
        else if (en)  h_q <= h_nx;
      end
    end
  end

`ifdef ZZADD_PIPE_OVF_EN
  localparam int unsigned ML = CW - 1;
  localparam logic [CW:0] MM = (ONE << ML) - ONE;

  logic [CW:0] m_sum;
  logic        ovf_q;

  assign m_sum = {1'b0, g_st[STAGES-1].a_in[CW-1:0] & MM[CW-1:0]}
               + {1'b0, g_st[STAGES-1].b_in[CW-1:0] & MM[CW-1:0]}
               + (CW + 1)'(g_st[STAGES-1].c_in);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l)  ovf_q <= 1'b0;
    else if (en)  ovf_q <= (m_sum > MM) ^ g_st[STAGES-1].c_nx;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_vld   = g_st[STAGES-1].v_q;
  assign adder_out = g_st[STAGES-1].r_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign cout_half = g_st[STAGES-1].g_h.h_q;

endmodule

// File: tb/tb_zzadd_pipe.sv
// Scoreboard bench for zzadd_pipe (WIDTH=64, STAGES=4): directed corners, back-to-back, stall, reset, random.
module tb_zzadd_pipe;

  logic        rclk = 1'b0;
  logic        arst_l = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [63:0] rs1_data = '0;
  logic [63:0] rs2_data = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [63:0] adder_out;
  logic        cout_half;
  logic        cout;
  logic        ovf;

  zzadd_pipe #(.WIDTH(64), .STAGES(4)) dut (
    .rclk      (rclk),
    .arst_l    (arst_l),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .cin       (cin),
    .sub       (sub),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .adder_out (adder_out),
    .cout_half (cout_half),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ch;
    logic        ov;
    int          acc;
    int          st;
  } exp_t;

  exp_t sb[$];
  exp_t acc_e;
  exp_t pop_e;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   rdy_mode = 1;
  logic quiet = 1'b0;
  logic fin_req = 1'b0;
  logic fin_seen = 1'b0;
  logic drv_timeout = 1'b0;

  logic        held = 1'b0;
  logic [63:0] snap_sum;
  logic        snap_co, snap_ch, snap_ov;

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic s);
    exp_t        e;
    logic [63:0] bb;
    logic [64:0] full;
    logic [32:0] low;
    bb    = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + 65'(c);
    low   = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + 33'(c);
    e.sum = full[63:0];
    e.co  = full[64];
    e.ch  = low[32];
`ifdef ZZADD_PIPE_OVF_EN
    e.ov  = (a[63] == bb[63]) && (e.sum[63] != a[63]);
`else
    e.ov  = 1'b0;
`endif
    e.acc = 0;
    e.st  = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Acceptance and stall bookkeeping on the active edge (pre-update values).
  always @(posedge rclk) begin
    if (arst_l && in_vld && in_rdy) begin
      acc_e     = model(rs1_data, rs2_data, cin, sub);
      acc_e.acc = cyc;
      acc_e.st  = stalls;
      sb.push_back(acc_e);
    end
    if (arst_l && out_vld && !out_rdy) stalls++;
    cyc++;
  end

  always @(posedge rclk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b0;
      1:       out_rdy = 1'b1;
      default: out_rdy = ($urandom_range(3) != 0);
    endcase
  end

  always @(negedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      #1;
      check("rst_out_vld", 64'(out_vld), 64'd0);
      check("rst_adder_out", adder_out, 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_cout_half", 64'(cout_half), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_in_rdy", 64'(in_rdy), 64'd1);
      sb.delete();
      held = 1'b0;
    end else begin
      if (quiet) check("quiet_out_vld", 64'(out_vld), 64'd0);
      check("in_rdy_vs_stall", 64'(in_rdy), 64'(!(out_vld && !out_rdy)));
      if (held) begin
        check("stall_out_vld", 64'(out_vld), 64'd1);
        check("stall_adder_out", adder_out, snap_sum);
        check("stall_cout", 64'(cout), 64'(snap_co));
        check("stall_cout_half", 64'(cout_half), 64'(snap_ch));
        check("stall_ovf", 64'(ovf), 64'(snap_ov));
      end
      if (out_vld && !out_rdy) begin
        held     = 1'b1;
        snap_sum = adder_out;
        snap_co  = cout;
        snap_ch  = cout_half;
        snap_ov  = ovf;
      end else begin
        held = 1'b0;
      end
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          pop_e = sb.pop_front();
          check("adder_out", adder_out, pop_e.sum);
          check("cout", 64'(cout), 64'(pop_e.co));
          check("cout_half", 64'(cout_half), 64'(pop_e.ch));
          check("ovf", 64'(ovf), 64'(pop_e.ov));
          check("latency", 64'(cyc - pop_e.acc), 64'(4 + stalls - pop_e.st));
        end
      end
      if (fin_req && !fin_seen) begin
        fin_seen = 1'b1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("send_timeout", 64'(drv_timeout), 64'd0);
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
    int n;
    rs1_data = a;
    rs2_data = b;
    cin      = c;
    sub      = s;
    in_vld   = 1'b1;
    n = 0;
    while (!in_rdy && n < 100) begin
      @(posedge rclk); #2;
      n++;
    end
    if (n >= 100) drv_timeout = 1'b1;
    @(posedge rclk); #2;
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge rclk); #2;
    end
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1 arst_l = 1'b0;
    idle(3);
    arst_l = 1'b1;
    idle(2);

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    send(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    send(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1);
    idle(8);

    for (int i = 1; i <= 8; i++) send(64'(i), 64'(i), 1'b0, 1'b0);
    idle(8);

    rdy_mode = 0;
    idle(1);
    for (int i = 0; i < 4; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    rs1_data = 64'hDEAD_BEEF_DEAD_BEEF;
    rs2_data = 64'h1234_5678_9ABC_DEF0;
    in_vld   = 1'b1;
    idle(3);
    in_vld   = 1'b0;
    rdy_mode = 1;
    idle(8);

    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    arst_l = 1'b0;
    idle(1);
    arst_l = 1'b1;
    quiet  = 1'b1;
    idle(6);
    quiet  = 1'b0;

    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(4) == 0) idle(1);
      send(rnd64(), rnd64(), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    rdy_mode = 1;
    idle(12);

    fin_req = 1'b1;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/zzadd_pipe.md
ZZADD_PIPE -- requirements
Module: zzadd_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; even and a multiple of STAGES.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth in cycles; 1..WIDTH/2.
REQ-003 SHALL have port rclk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port arst_l  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_vld  input  1  operand set valid.
REQ-006 SHALL have port in_rdy  output  1  block accepts operands this cycle.
REQ-007 SHALL have port rs1_data  input  WIDTH  first operand.
REQ-008 SHALL have port rs2_data  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry in.
REQ-010 SHALL have port sub  input  1  1 = use ~rs2_data.
REQ-011 SHALL have port out_vld  output  1  result valid.
REQ-012 SHALL have port out_rdy  input  1  consumer takes result this cycle.
REQ-013 SHALL have port adder_out  output  WIDTH  sum.
REQ-014 SHALL have port cout_half  output  1  carry out of bit WIDTH/2-1.
REQ-015 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-016 SHALL have port ovf  output  1  signed two's-complement overflow.

Function
REQ-017 SHALL compute adder_out = rs1_data + (sub ? ~rs2_data : rs2_data) + cin, modulo 2^WIDTH; caller sets cin=1 for true subtract.
REQ-018 SHALL split the add into STAGES equal chunks of WIDTH/STAGES bits; stage k adds chunk k with the registered carry from stage k-1; unprocessed operand chunks and finished result chunks skew-delayed alongside.
REQ-019 SHALL accept operands when in_vld & in_rdy; out_vld asserts exactly STAGES cycles after acceptance absent stalls.
REQ-020 SHALL sustain one accepted operand set per cycle when out_rdy stays high.
REQ-021 SHALL define stall = out_vld & ~out_rdy; in_rdy = ~stall; on stall every stage holds (no bubble collapse).
REQ-022 SHALL hold adder_out, cout_half, cout, ovf, out_vld stable while stalled.
REQ-023 SHALL ignore in_vld and operands while in_rdy is low; no entry, no corruption.
REQ-024 SHALL report cout_half from the same operand set as adder_out, regardless of which stage computes bit WIDTH/2-1.
REQ-025 SHALL compute ovf = carry into MSB XOR carry out of MSB (when enabled, see REQ-030).
REQ-026 SHALL, for STAGES=1, register the full combinational result; latency 1.
REQ-027 SHALL deliver results in acceptance order; no drops, no duplicates.

Reset
REQ-028 SHALL on arst_l low immediately clear all stage valid flags, out_vld=0, adder_out=0, cout_half=0, cout=0, ovf=0, in_rdy=1, independent of rclk.
REQ-029 SHALL discard all in-flight operations on reset mid-operation; after release, nothing emitted until new operands accepted.

Configuration
REQ-030 SHALL, with ZZADD_PIPE_OVF_EN defined, implement ovf per REQ-025 with MSB carry-in carried through the final stage; without it, ovf tied 0 and no overflow logic/flops instantiated, port retained.

Verification (WIDTH=64, STAGES=4)
REQ-031 SHALL cover: 0xFFFFFFFFFFFFFFFF + 0, cin=1, sub=0 -> adder_out=0, cout=1, cout_half=1, ovf=0, out_vld 4 cycles after accept.
REQ-032 SHALL cover: 0x00000000FFFFFFFF + 1, cin=0 -> adder_out=0x0000000100000000, cout_half=1, cout=0.
REQ-033 SHALL cover: 0x8000000000000000 with rs2=1, sub=1, cin=1 -> adder_out=0x7FFFFFFFFFFFFFFF, cout=1, ovf=1 with ZZADD_PIPE_OVF_EN, ovf=0 without.
REQ-034 SHALL cover: 8 back-to-back sets (i + i, i=1..8), out_rdy=1 -> results 2..16 on 8 consecutive cycles starting cycle 4.
REQ-035 SHALL cover: pipeline full, out_rdy low 3 cycles -> in_rdy=0 those cycles, adder_out unchanged, all 4 results later emitted in order.
REQ-036 SHALL cover: arst_l low for 1 cycle with 3 ops in flight -> out_vld=0 immediately, no output within 6 cycles of release without new input.
